// File: rtl/idma_rd_sync_resi_pair_add.sv
// Residual pair adder: holds each fmapA beat, adds the following fmapB beat lane-wise
// with signed int8 saturation, and returns one sum per pair over a valid/ready output.
module idma_rd_sync_resi_pair_add #(
  parameter int DATA_W = 128,
  parameter int LANE_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_rd_resi_mode,
  input  logic              i_rd_req,
  input  logic [CNT_W-1:0]  i_rd_resi_loop_num,
  input  logic              i_rsp_valid,
  input  logic [DATA_W-1:0] i_rsp_data,
  output logic              o_rsp_ready,
  output logic              o_out_valid,
  output logic [DATA_W-1:0] o_out_data,
  input  logic              i_out_ready,
  output logic              o_resi_busy,
  output logic              o_resi_done
);

  localparam int LANES = DATA_W / LANE_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_A,
    S_WAIT_B,
    S_DRAIN
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_a_buf;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_valid;
  logic                r_resi_done;
  logic [CNT_W-1:0]    r_loop_num;
  logic [CNT_W-1:0]    r_pair_cnt;

  logic [DATA_W-1:0]   w_sum;
  logic                w_rsp_ready;
  logic                w_rsp_acc;
  logic                w_out_hs;
  logic                w_last;
  logic                w_load;

  // Overflow exists exactly when the 9-bit sign and the 8-bit sign disagree;
  // the 9-bit sign then tells which rail to clamp to.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [LANE_W-1:0] w_a;
      logic [LANE_W-1:0] w_b;
      logic [LANE_W:0]   w_s;
      assign w_a = r_a_buf[gi*LANE_W +: LANE_W];
      assign w_b = i_rsp_data[gi*LANE_W +: LANE_W];
      assign w_s = {w_a[LANE_W-1], w_a} + {w_b[LANE_W-1], w_b};
      assign w_sum[gi*LANE_W +: LANE_W] = (w_s[LANE_W] != w_s[LANE_W-1])
                                          ? {w_s[LANE_W], {(LANE_W-1){~w_s[LANE_W]}}}
                                          : w_s[LANE_W-1:0];
    end
  endgenerate

  // A B beat is only taken when the output register is free or emptying this cycle.
  always_comb begin
    w_rsp_ready = 1'b0;
    case (r_state)
      S_WAIT_A: w_rsp_ready = 1'b1;
      S_WAIT_B: w_rsp_ready = ~r_out_valid | i_out_ready;
      default:  w_rsp_ready = 1'b0;
    endcase
  end

  assign w_rsp_acc = i_rsp_valid & w_rsp_ready;
  assign w_out_hs  = r_out_valid & i_out_ready;
  assign w_last    = (r_pair_cnt == (r_loop_num - CNT_W'(1)));
  assign w_load    = (r_state == S_WAIT_B) & w_rsp_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a_buf     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_resi_done <= 1'b0;
      r_loop_num  <= '0;
      r_pair_cnt  <= '0;
    end else begin
      r_resi_done <= 1'b0;

      // A new sum loading in the same cycle as a drain keeps out_valid high.
      if (w_load) begin
        r_out_data  <= w_sum;
        r_out_valid <= 1'b1;
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (i_rd_req && i_rd_resi_mode && (i_rd_resi_loop_num != '0)) begin
            r_loop_num <= i_rd_resi_loop_num;
            r_pair_cnt <= '0;
            r_state    <= S_WAIT_A;
          end
        end
        S_WAIT_A: begin
          if (w_rsp_acc) begin
            r_a_buf <= i_rsp_data;
            r_state <= S_WAIT_B;
          end
        end
        S_WAIT_B: begin
          if (w_rsp_acc) begin
            r_pair_cnt <= r_pair_cnt + CNT_W'(1);
            r_state    <= w_last ? S_DRAIN : S_WAIT_A;
          end
        end
        S_DRAIN: begin
          if (w_out_hs) begin
            r_resi_done <= 1'b1;
            r_pair_cnt  <= '0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rsp_ready = w_rsp_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_resi_busy = (r_state != S_IDLE);
  assign o_resi_done = r_resi_done;

endmodule
